// File: rtl/serial_subtractor_fsm.sv
// Purpose : bit-serial unsigned subtractor, diff = (a - b - borrow_in) mod 2^WIDTH, LSB first.
// Latency : done pulses WIDTH cycles after the accepting edge; busy spans WIDTH+1 cycles.
// Backpr. : start is sampled only in IDLE; requests while busy are dropped, never queued.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, a, b,      request and operands; captured on the edge that accepts start
//   borrow_in
//   busy              high whenever the FSM is not in IDLE (registered)
//   done              one-cycle pulse when diff/borrow_out are freshly loaded
//   diff, borrow_out  result and final borrow, held until the next completion
//   overflow          signed overflow flag, only when SUB_OVERFLOW_EN is defined
//
// Build option: define SUB_OVERFLOW_EN to add the overflow output.

module serial_subtractor_fsm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               br_q, br_d;
    // Holds the WIDTH-1 most recent result bits; the final bit is merged
    // straight into diff on the last edge, so no extra slot is needed.
    logic [WIDTH-2:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SUB_OVERFLOW_EN
    logic               overflow_q, overflow_d;
`endif

    // One full-subtractor cell working on the current LSBs of the shifters.
    logic               a_bit;
    logic               b_bit;
    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   res_shifted;

    assign a_bit       = a_sh_q[0];
    assign b_bit       = b_sh_q[0];
    assign d_bit       = a_bit ^ b_bit ^ br_q;
    assign br_next     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign res_shifted = {d_bit, res_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        br_d         = br_q;
        res_d        = res_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
        overflow_d   = overflow_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                res_d  = res_shifted[WIDTH-1:1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Last bit: the cell sees the operand MSBs and produces the
                    // result MSB, which is all the overflow term needs.
                    diff_d       = res_shifted;
                    borrow_out_d = br_next;
`ifdef SUB_OVERFLOW_EN
                    overflow_d   = (a_bit ^ b_bit) & (d_bit ^ a_bit);
`endif
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state register rather than lagging it by a cycle.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            br_q         <= 1'b0;
            res_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            br_q         <= br_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SUB_OVERFLOW_EN
            overflow_q   <= overflow_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    assign overflow   = overflow_q;
`endif

endmodule
